latency_stats: RTL and testbench

//  Downstream consumer of the loopback first-byte latency counter, in the i_tx_clk domain.

---
 rtl/latency_stats_if.sv | 49 ++++
 rtl/latency_stats.sv | 145 ++++++++++++++
 tb/tb_latency_stats.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/latency_stats_if.sv
// Strobe, clear and statistics bundle for the loopback latency statistics block.
// The master drives strobes and clear; the slave (the stats block) drives the statistics.
interface latency_stats_if #(
    parameter int LAT_W = 6,
    parameter int CNT_W = 16
);
    logic                   i_first_byte_sent;
    logic                   i_sync_byte_received;
    logic [LAT_W-1:0]       i_latency;
    logic                   i_clear;
    logic [LAT_W-1:0]       o_last;
    logic [LAT_W-1:0]       o_min;
    logic [LAT_W-1:0]       o_max;
    logic [LAT_W+CNT_W-1:0] o_sum;
    logic [CNT_W-1:0]       o_count;
    logic [CNT_W-1:0]       o_timeouts;
    logic                   o_sample_valid;
    logic                   o_saturated;

    modport master (
        output i_first_byte_sent,
        output i_sync_byte_received,
        output i_latency,
        output i_clear,
        input  o_last,
        input  o_min,
        input  o_max,
        input  o_sum,
        input  o_count,
        input  o_timeouts,
        input  o_sample_valid,
        input  o_saturated
    );

    modport slave (
        input  i_first_byte_sent,
        input  i_sync_byte_received,
        input  i_latency,
        input  i_clear,
        output o_last,
        output o_min,
        output o_max,
        output o_sum,
        output o_count,
        output o_timeouts,
        output o_sample_valid,
        output o_saturated
    );
endinterface

// File: rtl/latency_stats.sv
// Loopback first-byte latency statistics: follows send/sync strobes, samples the
// frozen latency one cycle after sync and keeps min/max/sum/count plus timeouts.
module latency_stats #(
    parameter int LAT_W       = 6,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic             i_tx_clk,
    input  logic             i_rst_n,
    latency_stats_if.slave   bus
);
    localparam int SUM_W = LAT_W + CNT_W;
    localparam logic [LAT_W-1:0] TMO_LIM = LAT_W'(TIMEOUT_CYC);
    localparam logic [LAT_W-1:0] T_ONE   = LAT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LAT_W-1:0] timer_q;
    logic [LAT_W-1:0] timer_d;
    logic             take;
    logic             tmo_hit;

    logic [LAT_W-1:0] last_q;
    logic [LAT_W-1:0] min_q;
    logic [LAT_W-1:0] max_q;
    logic [SUM_W-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] tmo_q;
    logic             vld_q;
    logic             sat;

    assign sat = &cnt_q;

    // Measurement state and armed-cycle timer registers.
    always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state: a send always (re)arms, sync stops, timer expiry abandons.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        take    = 1'b0;
        tmo_hit = 1'b0;
        if (bus.i_clear) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_first_byte_sent) begin
                        state_d = ARMED;
                        timer_d = T_ONE;
                    end
                end
                ARMED: begin
                    if (bus.i_first_byte_sent) begin
                        timer_d = T_ONE;
                    end else if (bus.i_sync_byte_received) begin
                        state_d = CAPTURE;
                    end else if (timer_q == TMO_LIM) begin
                        state_d = IDLE;
                        timer_d = '0;
                        tmo_hit = 1'b1;
                    end else begin
                        timer_d = timer_q + T_ONE;
                    end
                end
                CAPTURE: begin
                    take = 1'b1;
                    if (bus.i_first_byte_sent) begin
                        state_d = ARMED;
                        timer_d = T_ONE;
                    end else begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Statistics accumulate on each capture until the sample count saturates.
    always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= '0;
            min_q  <= '1;
            max_q  <= '0;
            sum_q  <= '0;
            cnt_q  <= '0;
            tmo_q  <= '0;
            vld_q  <= 1'b0;
        end else if (bus.i_clear) begin
            last_q <= '0;
            min_q  <= '1;
            max_q  <= '0;
            sum_q  <= '0;
            cnt_q  <= '0;
            tmo_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (take && !sat) begin
                last_q <= bus.i_latency;
                if (bus.i_latency < min_q) begin
                    min_q <= bus.i_latency;
                end
                if (bus.i_latency > max_q) begin
                    max_q <= bus.i_latency;
                end
                sum_q <= sum_q + SUM_W'(bus.i_latency);
                cnt_q <= cnt_q + CNT_W'(1);
                vld_q <= 1'b1;
            end
            if (tmo_hit && !(&tmo_q)) begin
                tmo_q <= tmo_q + CNT_W'(1);
            end
        end
    end

    assign bus.o_last         = last_q;
    assign bus.o_min          = min_q;
    assign bus.o_max          = max_q;
    assign bus.o_sum          = sum_q;
    assign bus.o_count        = cnt_q;
    assign bus.o_timeouts     = tmo_q;
    assign bus.o_sample_valid = vld_q;
    assign bus.o_saturated    = sat;
endmodule

// File: tb/tb_latency_stats.sv
// Bench for latency_stats: two instances (wide and 4-bit counters) share stimulus
// and are compared every cycle against a measurement-level model.
module tb_latency_stats;
    localparam int TMO = 63;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_send = 1'b0;
    logic s_sync = 1'b0;
    logic [5:0] s_lat = '0;
    logic s_clr = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    latency_stats_if #(.LAT_W(6), .CNT_W(16)) b0 ();
    latency_stats_if #(.LAT_W(6), .CNT_W(4))  b1 ();

    assign b0.i_first_byte_sent    = s_send;
    assign b0.i_sync_byte_received = s_sync;
    assign b0.i_latency            = s_lat;
    assign b0.i_clear              = s_clr;
    assign b1.i_first_byte_sent    = s_send;
    assign b1.i_sync_byte_received = s_sync;
    assign b1.i_latency            = s_lat;
    assign b1.i_clear              = s_clr;

    latency_stats #(.LAT_W(6), .CNT_W(16), .TIMEOUT_CYC(TMO)) u0 (
        .i_tx_clk (clk),
        .i_rst_n  (rst_n),
        .bus      (b0.slave)
    );

    latency_stats #(.LAT_W(6), .CNT_W(4), .TIMEOUT_CYC(TMO)) u1 (
        .i_tx_clk (clk),
        .i_rst_n  (rst_n),
        .bus      (b1.slave)
    );

    // ph: 0 = no measurement, 1 = waiting for sync (w cycles since send),
    // 2 = sync seen, latency sampled this cycle.
    typedef struct {
        int     ph;
        int     w;
        int     last;
        int     mn;
        int     mx;
        longint sum;
        int     cnt;
        int     tmo;
        bit     vld;
    } mdl_t;

    mdl_t m0;
    mdl_t m1;

    function automatic mdl_t fresh();
        mdl_t r;
        r.ph = 0; r.w = 0; r.last = 0; r.mn = 63; r.mx = 0;
        r.sum = 0; r.cnt = 0; r.tmo = 0; r.vld = 0;
        return r;
    endfunction

    function automatic mdl_t step(mdl_t m, bit s, bit y, int lat,
                                  bit clr, int cmax);
        mdl_t n = m;
        n.vld = 0;
        if (clr) return fresh();
        if (m.ph == 0) begin
            if (s) begin n.ph = 1; n.w = 1; end
        end else if (m.ph == 1) begin
            if (s) n.w = 1;
            else if (y) n.ph = 2;
            else if (m.w == TMO) begin
                n.ph = 0;
                if (m.tmo < cmax) n.tmo = m.tmo + 1;
            end else n.w = m.w + 1;
        end else begin
            if (m.cnt < cmax) begin
                n.last = lat;
                n.mn = (lat < m.mn) ? lat : m.mn;
                n.mx = (lat > m.mx) ? lat : m.mx;
                n.sum = m.sum + lat;
                n.cnt = m.cnt + 1;
                n.vld = 1;
            end
            n.ph = s ? 1 : 0;
            n.w = 1;
        end
        return n;
    endfunction

    task automatic cmp(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_models();
        cmp("u0_last", b0.o_last, m0.last);
        cmp("u0_min", b0.o_min, m0.mn);
        cmp("u0_max", b0.o_max, m0.mx);
        cmp("u0_sum", b0.o_sum, m0.sum);
        cmp("u0_count", b0.o_count, m0.cnt);
        cmp("u0_tmo", b0.o_timeouts, m0.tmo);
        cmp("u0_vld", b0.o_sample_valid, m0.vld);
        cmp("u0_sat", b0.o_saturated, m0.cnt == 65535);
        cmp("u1_last", b1.o_last, m1.last);
        cmp("u1_min", b1.o_min, m1.mn);
        cmp("u1_max", b1.o_max, m1.mx);
        cmp("u1_sum", b1.o_sum, m1.sum);
        cmp("u1_count", b1.o_count, m1.cnt);
        cmp("u1_tmo", b1.o_timeouts, m1.tmo);
        cmp("u1_vld", b1.o_sample_valid, m1.vld);
        cmp("u1_sat", b1.o_saturated, m1.cnt == 15);
    endtask

    // One clock cycle: apply inputs, check at negedge, advance model, end #1 after posedge.
    task automatic cyc(bit s, bit y, int lat, bit clr);
        s_send = s; s_sync = y; s_lat = 6'(lat); s_clr = clr;
        @(negedge clk);
        check_models();
        m0 = step(m0, s, y, lat, clr, 65535);
        m1 = step(m1, s, y, lat, clr, 15);
        @(posedge clk);
        #1;
    endtask

    task automatic measure(int lat, int gap);
        cyc(1, 0, lat, 0);
        for (int i = 0; i < gap; i++) cyc(0, 0, lat, 0);
        cyc(0, 1, lat, 0);
        cyc(0, 0, lat, 0);
    endtask

    initial begin
        m0 = fresh();
        m1 = fresh();
        @(negedge clk);
        cmp("rst_min", b0.o_min, 63);
        cmp("rst_max", b0.o_max, 0);
        cmp("rst_sum", b0.o_sum, 0);
        cmp("rst_count", b0.o_count, 0);
        cmp("rst_tmo", b0.o_timeouts, 0);
        cmp("rst_vld", b0.o_sample_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc(1, 0, 10, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 10, 0);
        cyc(0, 1, 10, 0);
        cyc(0, 0, 10, 0);
        cmp("t2_last", b0.o_last, 10);
        cmp("t2_min", b0.o_min, 10);
        cmp("t2_max", b0.o_max, 10);
        cmp("t2_sum", b0.o_sum, 10);
        cmp("t2_count", b0.o_count, 1);
        cmp("t2_vld", b0.o_sample_valid, 1);
        cyc(0, 0, 0, 0);
        cmp("t2_vld_off", b0.o_sample_valid, 0);

        cyc(0, 0, 0, 1);
        measure(12, 2);
        measure(5, 0);
        measure(30, 4);
        cmp("t3_min", b0.o_min, 5);
        cmp("t3_max", b0.o_max, 30);
        cmp("t3_sum", b0.o_sum, 47);
        cmp("t3_count", b0.o_count, 3);

        cyc(0, 0, 0, 1);
        cyc(1, 0, 20, 0);
        for (int i = 0; i < 63; i++) cyc(0, 0, 20, 0);
        cmp("t4_tmo", b0.o_timeouts, 1);
        cmp("t4_count", b0.o_count, 0);
        cyc(0, 0, 20, 1);
        cyc(1, 0, 20, 0);
        for (int i = 0; i < 62; i++) cyc(0, 0, 20, 0);
        cyc(0, 1, 20, 0);
        cyc(0, 0, 20, 0);
        cmp("t4_late_count", b0.o_count, 1);
        cmp("t4_late_tmo", b0.o_timeouts, 0);

        cyc(0, 0, 0, 1);
        cyc(1, 0, 3, 0);
        cyc(1, 1, 3, 0);
        cyc(0, 0, 3, 0);
        cyc(0, 0, 3, 0);
        cmp("t5_no_cap", b0.o_count, 0);
        cyc(0, 1, 7, 0);
        cyc(1, 0, 7, 0);
        cyc(0, 1, 9, 0);
        cyc(0, 0, 9, 0);
        cmp("t5_count", b0.o_count, 2);
        cmp("t5_sum", b0.o_sum, 16);

        cyc(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) measure(i + 1, 1);
        cmp("t6_count", b1.o_count, 15);
        cmp("t6_sat", b1.o_saturated, 1);
        cmp("t6_sum", b1.o_sum, 120);
        cmp("t6_wide_count", b0.o_count, 16);
        cyc(0, 0, 0, 1);
        cmp("t6_clr_count", b1.o_count, 0);
        cmp("t6_clr_sat", b1.o_saturated, 0);
        cmp("t6_clr_min", b1.o_min, 63);

        for (int i = 0; i < 4000; i++) begin
            bit quiet;
            quiet = ((i / 500) % 2) == 1;
            if (i == 2200) begin
                rst_n = 1'b0;
                m0 = fresh();
                m1 = fresh();
                @(negedge clk);
                check_models();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            cyc(quiet ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 7) == 0),
                quiet ? ($urandom_range(0, 119) == 0) : ($urandom_range(0, 5) == 0),
                int'($urandom_range(0, 63)),
                $urandom_range(0, 299) == 0);
        end
        cyc(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
